// File: rtl/regress_sample_streamer_if.sv
// Sample write port for regress_sample_streamer.
// master: upstream drives in_valid/in_x/in_y; slave: streamer drives in_ready.
interface regress_sample_streamer_if #(
  parameter int XW = 3,
  parameter int YW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;

  modport master (
    output in_valid,
    output in_x,
    output in_y,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_x,
    input  in_y,
    output in_ready
  );
endinterface

// File: rtl/regress_sample_streamer.sv
// Streams frame_len buffered (x,y) samples as (xi, xi*xi, yi) beats.
// Ports: clk, rst, s (sample port), go, frame_len, start/xi/xi2/yi/last, busy, done.
module regress_sample_streamer #(
  parameter int XW    = 3,
  parameter int YW    = 3,
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  regress_sample_streamer_if.slave s,
  input  logic                  go,
  input  logic [CW-1:0]         frame_len,
  output logic                  start,
  output logic [XW-1:0]         xi,
  output logic [2*XW-1:0]       xi2,
  output logic [YW-1:0]         yi,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FIN
  } state_t;

  state_t state, state_n;

  logic [XW+YW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CW-1:0]    remaining;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic final_pop;

  logic [XW+YW-1:0] rd_data;
  logic [XW-1:0]    rd_x;
  logic [YW-1:0]    rd_y;
  logic [2*XW-1:0]  rd_x_ext;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign s.in_ready = !full;
  assign push       = s.in_valid && !full;
  assign final_pop  = pop && (remaining == CW'(1));

  assign rd_data  = mem[rd_ptr];
  assign rd_x     = rd_data[XW+YW-1:YW];
  assign rd_y     = rd_data[YW-1:0];
  assign rd_x_ext = {{XW{1'b0}}, rd_x};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s.in_x, s.in_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go && frame_len != '0) state_n = STREAM;
      STREAM:  if (final_pop) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    pop  = (state == STREAM) && !empty;
  end

  // go is only honoured in IDLE, so a go while busy never reloads the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (state == IDLE && go) begin
      remaining <= frame_len;
    end else if (pop) begin
      remaining <= remaining - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start <= 1'b0;
      xi    <= '0;
      xi2   <= '0;
      yi    <= '0;
      last  <= 1'b0;
      done  <= 1'b0;
    end else begin
      start <= pop;
      last  <= final_pop;
      xi    <= pop ? rd_x : '0;
      xi2   <= pop ? rd_x_ext * rd_x_ext : '0;
      yi    <= pop ? rd_y : '0;
      done  <= (state == FIN) ||
               (state == IDLE && go && frame_len == '0);
    end
  end

endmodule

// File: tb/tb_regress_sample_streamer.sv
// Directed self-checking bench for regress_sample_streamer.
// Steps are taken 1ns after each rising edge.
module tb_regress_sample_streamer;
  localparam int XW    = 3;
  localparam int YW    = 3;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            go;
  logic [CW-1:0]   frame_len;
  logic            start;
  logic [XW-1:0]   xi;
  logic [2*XW-1:0] xi2;
  logic [YW-1:0]   yi;
  logic            last;
  logic            busy;
  logic            done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regress_sample_streamer_if #(.XW(XW), .YW(YW)) sif ();

  regress_sample_streamer #(
    .XW(XW), .YW(YW), .DEPTH(DEPTH), .CW(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (sif.slave),
    .go        (go),
    .frame_len (frame_len),
    .start     (start),
    .xi        (xi),
    .xi2       (xi2),
    .yi        (yi),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y);
    sif.in_valid = 1'b1;
    sif.in_x     = XW'(x);
    sif.in_y     = YW'(y);
    step();
    sif.in_valid = 1'b0;
  endtask

  task automatic fire(input int len);
    go        = 1'b1;
    frame_len = CW'(len);
    step();
    go        = 1'b0;
  endtask

  task automatic beat(input string tag, input int x, input int y,
                      input int lst);
    chk({tag, "_start"}, int'(start), 1);
    chk({tag, "_xi"},    int'(xi),    x);
    chk({tag, "_xi2"},   int'(xi2),   x * x);
    chk({tag, "_yi"},    int'(yi),    y);
    chk({tag, "_last"},  int'(last),  lst);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"},  int'(done),  1);
    chk({tag, "_busy"},  int'(busy),  0);
    chk({tag, "_start"}, int'(start), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, a4;
    int acc;
    int bi;
    int pv [6] = '{1, 0, 0, 1, 1, 1};
    int px [6] = '{1, 0, 0, 2, 3, 4};
    int sv [6] = '{1, 0, 0, 1, 1, 1};
    int bx [4] = '{1, 2, 3, 4};

    rst          = 1'b1;
    go           = 1'b0;
    frame_len    = '0;
    sif.in_valid = 1'b0;
    sif.in_x     = '0;
    sif.in_y     = '0;
    step();
    step();

    chk("rst_start", int'(start), 0);
    chk("rst_xi",    int'(xi),    0);
    chk("rst_xi2",   int'(xi2),   0);
    chk("rst_yi",    int'(yi),    0);
    chk("rst_last",  int'(last),  0);
    chk("rst_done",  int'(done),  0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_ready", int'(sif.in_ready), 1);
    rst = 1'b0;
    step();

    // basic frame of five
    for (int i = 0; i < 5; i++) push(i, i);
    fire(5);
    chk("t1_busy",  int'(busy),  1);
    chk("t1_nobeat", int'(start), 0);
    a0 = 0; a1 = 0; a2 = 0; a3 = 0; a4 = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      beat("t1_beat", k, k, int'(k == 4));
      if (start) begin
        a0 += 1;
        a1 += int'(xi);
        a2 += int'(xi2);
        a3 += int'(xi) * int'(xi2);
        a4 += int'(xi2) * int'(xi2);
      end
    end
    step();
    chk_done("t1");
    chk("t1_ans0", a0, 5);
    chk("t1_ans1", a1, 10);
    chk("t1_ans2", a2, 30);
    chk("t1_ans3", a3, 100);
    chk("t1_ans4", a4, 354);
    step();
    chk("t1_done_pulse", int'(done), 0);

    // underflow bubbles
    fire(4);
    chk("t2_busy", int'(busy), 1);
    bi = 0;
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        sif.in_valid = pv[k][0];
        sif.in_x     = XW'(px[k]);
        sif.in_y     = YW'(px[k]);
      end else begin
        sif.in_valid = 1'b0;
      end
      step();
      if (k >= 1) begin
        chk("t2_start", int'(start), sv[k-1]);
        if (sv[k-1] == 1) begin
          chk("t2_xi",   int'(xi),   bx[bi]);
          chk("t2_last", int'(last), int'(bi == 3));
          bi++;
        end else begin
          chk("t2_bub_last", int'(last), 0);
        end
      end
    end
    step();
    chk_done("t2");

    // full FIFO
    acc = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      sif.in_valid = 1'b1;
      sif.in_x     = XW'(i);
      sif.in_y     = YW'(i);
      if (sif.in_ready) acc++;
      step();
    end
    sif.in_valid = 1'b0;
    chk("t3_accepts", acc, DEPTH);
    chk("t3_full",    int'(sif.in_ready), 0);
    fire(DEPTH);
    chk("t3_still_full", int'(sif.in_ready), 0);
    for (int k = 0; k < DEPTH; k++) begin
      step();
      beat("t3_beat", k, k, int'(k == DEPTH - 1));
      if (k == 0) chk("t3_ready_back", int'(sif.in_ready), 1);
    end
    step();
    chk_done("t3");

    // partial frame, then zero length in the done cycle
    for (int i = 1; i <= 6; i++) push(i, 7 - i);
    fire(2);
    for (int k = 0; k < 2; k++) begin
      step();
      beat("t4_beat", k + 1, 6 - k, int'(k == 1));
    end
    step();
    chk_done("t4");
    fire(0);
    chk_done("t4_zero");
    step();
    chk("t4_zero_pulse", int'(done),  0);
    chk("t4_zero_busy",  int'(busy),  0);
    chk("t4_zero_start", int'(start), 0);
    fire(4);
    for (int k = 0; k < 4; k++) begin
      step();
      beat("t4_rest", 3 + k, 4 - k, int'(k == 3));
    end
    step();
    chk_done("t4_rest");

    // max values, ignored go, reset abort
    push(7, 7);
    push(1, 1);
    push(2, 2);
    push(3, 3);
    fire(3);
    go        = 1'b1;
    frame_len = CW'(1);
    step();
    go = 1'b0;
    beat("t5_max", 7, 7, 0);
    chk("t5_xi2_49", int'(xi2), 49);
    step();
    beat("t5_beat2", 1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_start", int'(start), 0);
    chk("t5_rst_xi",    int'(xi),    0);
    chk("t5_rst_xi2",   int'(xi2),   0);
    chk("t5_rst_yi",    int'(yi),    0);
    chk("t5_rst_last",  int'(last),  0);
    chk("t5_rst_done",  int'(done),  0);
    chk("t5_rst_busy",  int'(busy),  0);
    chk("t5_rst_ready", int'(sif.in_ready), 1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_no_done",  int'(done),  0);
      chk("t5_no_start", int'(start), 0);
    end
    fire(1);
    step();
    step();
    chk("t5_empty_start", int'(start), 0);
    chk("t5_empty_busy",  int'(busy),  1);
    push(4, 5);
    chk("t5_wait_start", int'(start), 0);
    step();
    beat("t5_fresh", 4, 5, 1);
    step();
    chk_done("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regress_sample_streamer.md
# regress_sample_streamer

Sample source for the least-squares regression accumulators (the X^T X and X^T Y moment engines) in the option-pricing datapath. Upstream writes (x, y) path samples into an internal FIFO through a valid/ready port. A go pulse then streams exactly frame_len samples to the accumulators as a start-qualified beat stream carrying xi, xi2 = xi*xi and yi. The block marks the final beat and pulses done when the frame has fully left the block.

## Interface
- XW, 3, width of x samples
- YW, 3, width of y samples
- DEPTH, 8, FIFO entries (power of two, >= 2)
- CW, 8, width of frame_len and the internal remaining-sample counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  FIFO can accept; equals !full
- in_x  in  XW  sample x (unsigned)
- in_y  in  YW  sample y (unsigned)
- go  in  1  single-cycle request to stream one frame
- frame_len  in  CW  samples in the frame, sampled on go
- start  out  1  beat valid to accumulators (registered)
- xi  out  XW  beat x (registered)
- xi2  out  2*XW  beat x squared, full precision (registered)
- yi  out  YW  beat y (registered)
- last  out  1  high with start on the final beat of a frame (registered)
- busy  out  1  frame in progress; high when state != IDLE
- done  out  1  one-cycle pulse after the final beat

## Operation
- FIFO write: a push occurs when in_valid && in_ready.
  - in_ready = !full, so there is no push when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Pointers wrap modulo DEPTH. Occupancy count is clog2(DEPTH)+1 bits.
- FSM states: IDLE, STREAM, FIN.
  - IDLE: on go with frame_len != 0, latch remaining = frame_len and go to STREAM.
  - IDLE, go with frame_len == 0: no beats; done pulses the next cycle; busy stays low.
  - STREAM: pop one sample every cycle the FIFO is non-empty. Each pop decrements remaining.
  - Empty FIFO in STREAM: no pop; start deasserts next cycle (bubble) and the FSM waits. There is no timeout.
  - Pop with remaining == 1: go to FIN.
  - FIN: the final beat is on the outputs. Go to IDLE next cycle with done = 1.
- go while busy is ignored; frame_len is not re-sampled.
- Beat registers:
  - On a pop, next cycle: start = 1, xi = x, xi2 = x*x, yi = y, last = (remaining == 1).
  - Without a pop, next cycle: start = 0, last = 0, and xi/xi2/yi = 0.
- Pops never exceed frame_len. Samples beyond the frame stay in the FIFO for the next go.
- Writes are accepted in every state, including during streaming.

## Timing
- Reset values: start=0, xi=0, xi2=0, yi=0, last=0, done=0, busy=0, in_ready=1. FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-frame aborts the frame. FIFO contents are discarded, and no done is issued.
- Latency for go at edge t with a non-empty FIFO:
  - first pop happens in cycle t+1;
  - first beat is visible in cycle t+2;
  - busy is high from t+1.
- Back-to-back beats: with a FIFO that never empties, N samples produce N consecutive start cycles.
- done is high the cycle immediately after the last-beat cycle. busy is low in that same cycle.
- A new go is accepted in the done cycle.
- Bubbles: each empty-FIFO cycle during STREAM inserts exactly one start=0 cycle. Beat order equals write order.

## Test plan
- Basic frame:
  - Stimulus: push (x,y) = (0,0),(1,1),(2,2),(3,3),(4,4); frame_len=5; go.
  - Required: 5 consecutive start cycles with xi=0,1,2,3,4, xi2=0,1,4,9,16, yi=0..4; last only on the 5th beat; done one cycle later.
  - Attached XTX must read ans0..4 = 5,10,30,100,354.
- Underflow bubbles:
  - Stimulus: go with frame_len=4 and an empty FIFO; then push 1 sample, idle 2 cycles, push 3 samples.
  - Required: start pattern 1,0,0,1,1,1; last on the 4th beat; done next cycle.
- Full FIFO:
  - Stimulus: hold in_valid=1 for DEPTH+3 cycles with no go.
  - Required: in_ready drops after exactly DEPTH accepts; the 3 extra samples are not stored.
  - Then go with frame_len=DEPTH: all DEPTH beats come out in order; in_ready returns high after the first pop.
- Partial frame and zero length:
  - Stimulus: push 6; go with frame_len=2; then go with frame_len=0.
  - Required: 2 beats, then done; 4 samples remain in the FIFO. Zero-length go gives done only, with no start and busy=0.
- Ignored go and reset abort:
  - Stimulus: go with frame_len=3; go asserted again mid-frame; then rst asserted after the 2nd beat.
  - Required: the second go has no effect. On reset, all outputs return to reset values, no done pulses, and in_ready=1 with an empty FIFO.
- Max values (XW=3, YW=3):
  - Stimulus: stream a sample with x=7, y=7.
  - Required: xi2=49 with no truncation; yi=7.
